// File: rtl/clint_multi_if.sv
// Request/response bus for the CLINT register window.
// Every request is answered exactly one cycle later; there is no back-pressure.
interface clint_multi_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart CLINT: shared prescaled 64-bit mtime, plus per-hart msip and
// mtimecmp registers that drive software and timer interrupts.

module clint_hart (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime,
  input  logic        msip_we,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic [31:0] wdata,
  output logic        msip,
  output logic [63:0] cmp,
  output logic        mtip
);
  always_ff @(posedge clk) begin
    if (rst) begin
      msip <= 1'b0;
      cmp  <= '1;
      mtip <= 1'b0;
    end else begin
      if (msip_we) msip       <= wdata[0];
      if (lo_we)   cmp[31:0]  <= wdata;
      if (hi_we)   cmp[63:32] <= wdata;
      // Compares pre-update values, so mtip lags mtime/mtimecmp by one cycle.
      mtip <= (mtime >= cmp);
    end
  end
endmodule

module clint_multi #(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  clint_multi_if.slave         bus,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [63:0]          mtime_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]                 presc;
  logic                          tick;
  logic [63:0]                   mtime, mtime_nxt;
  logic [NUM_HARTS-1:0][63:0]    cmp;
  logic [31:0]                   off, rd;
  logic                          in_msip, in_cmp, in_mlo, in_mhi, err, wr_ok;

  assign off     = bus.req_addr - BASE_ADDR;
  assign in_msip = off < 32'(4 * NUM_HARTS);
  assign in_cmp  = (off >= 32'h4000) && (off < 32'h4000 + 32'(8 * NUM_HARTS));
  assign in_mlo  = off == 32'hBFF8;
  assign in_mhi  = off == 32'hBFFC;
  assign err     = (bus.req_addr[1:0] != 2'b00) || !(in_msip || in_cmp || in_mlo || in_mhi);
  assign wr_ok   = bus.req_valid && bus.req_we && !err;

  assign tick    = presc == PW'(TICK_DIV - 1);
  assign mtime_o = mtime;

  // A write to one half wins over the tick; the other half still advances.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr_ok && in_mlo) mtime_nxt[31:0]  = bus.req_wdata;
    if (wr_ok && in_mhi) mtime_nxt[63:32] = bus.req_wdata;
  end

  always_comb begin
    rd = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (in_msip && off[5:2] == 4'(h)) rd = {31'b0, msip[h]};
      if (in_cmp && off[6:3] == 4'(h))  rd = off[2] ? cmp[h][63:32] : cmp[h][31:0];
    end
    if (in_mlo) rd = mtime[31:0];
    if (in_mhi) rd = mtime[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      mtime         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      presc         <= tick ? '0 : presc + PW'(1);
      mtime         <= mtime_nxt;
      bus.rsp_valid <= bus.req_valid;
      bus.rsp_err   <= bus.req_valid && err;
      bus.rsp_rdata <= (bus.req_valid && !err && !bus.req_we) ? rd : '0;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    clint_hart u_hart (
      .clk     (clk),
      .rst     (rst),
      .mtime   (mtime),
      .msip_we (wr_ok && in_msip && off[5:2] == 4'(h)),
      .lo_we   (wr_ok && in_cmp && off[6:3] == 4'(h) && !off[2]),
      .hi_we   (wr_ok && in_cmp && off[6:3] == 4'(h) && off[2]),
      .wdata   (bus.req_wdata),
      .msip    (msip[h]),
      .cmp     (cmp[h]),
      .mtip    (mtip[h])
    );
  end
endmodule

// File: doc/clint_multi.md
CLINT_MULTI -- requirements
Module: clint_multi

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of harts served (1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0200_0000, physical base of the CLINT window.
REQ-003 SHALL have parameter TICK_DIV, default 1, clk cycles per mtime increment (>=1).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  bus access request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32  physical byte address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response strobe.
REQ-010 SHALL have port rsp_rdata  output  32  read data.
REQ-011 SHALL have port rsp_err  output  1  unmapped or misaligned access.
REQ-012 SHALL have port msip  output  NUM_HARTS  per-hart software interrupt pending.
REQ-013 SHALL have port mtip  output  NUM_HARTS  per-hart timer interrupt pending.
REQ-014 SHALL have port mtime_o  output  64  current mtime, for CSR time/timeh reads.

Function
REQ-015 SHALL decode offsets from BASE_ADDR: msip[h] at 0x0000+4h; mtimecmp[h] low/high at 0x4000+8h / 0x4004+8h; mtime low/high at 0xBFF8 / 0xBFFC.
REQ-016 SHALL treat every access as 32-bit; req_addr[1:0]!=0 or an offset outside the map is an error.
REQ-017 SHALL assert rsp_valid exactly one cycle after each accepted request (req_valid high), reads and writes alike, with no back-pressure.
REQ-018 SHALL register rsp_rdata with the value at request time; error reads return 0 with rsp_err=1; rsp_err is otherwise 0.
REQ-019 SHALL ignore error writes, leaving all state unchanged.
REQ-020 SHALL write only bit 0 of msip[h]; reads return {31'b0, msip[h]}.
REQ-021 SHALL run a prescaler counting 0..TICK_DIV-1; mtime increments by 1 in the cycle the prescaler wraps (every cycle when TICK_DIV=1).
REQ-022 SHALL increment mtime as a full 64-bit value, with carry from low to high; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-023 SHALL, on a same-cycle mtime write and tick, load req_wdata into the written half; the unwritten half takes its half of (mtime+1).
REQ-024 SHALL NOT reset the prescaler on an mtime write.
REQ-025 SHALL register mtip[h] each cycle as (mtime >= {mtimecmph[h], mtimecmp[h]}), unsigned 64-bit, evaluated on pre-update register values; this gives 1-cycle lag.
REQ-026 SHALL deassert mtip[h] on the cycle after mtimecmp[h] is raised above mtime; there is no sticky state.
REQ-027 SHALL have mtime_o equal the mtime register, with no extra latency.

Reset
REQ-028 SHALL, during rst, set mtime=0, prescaler=0, msip=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-029 SHALL drop any request presented during rst, with no response the following cycle.
REQ-030 SHALL start counting in the first cycle after rst deasserts, and SHALL keep mtip=0 after reset until software writes a mtimecmp.

Verification
REQ-031 SHALL cover: TICK_DIV=4, reset then 16 idle cycles -> mtime_o=4; mtip=0.
REQ-032 SHALL cover: NUM_HARTS=2, write mtimecmp[1] low=20, high=0 -> mtip[1] rises on the cycle after mtime reaches 20 (TICK_DIV=1); mtip[0] stays 0.
REQ-033 SHALL cover: write mtime low=0xFFFF_FFFF, high=0 -> next tick gives mtime=0x1_0000_0000; same-cycle write to high=5 during that tick -> high=5, low=0.
REQ-034 SHALL cover: write msip[1]=0xFFFF_FFFF, then read 0x0004 -> rdata=1, msip=2'b10, rsp_valid one cycle after each request.
REQ-035 SHALL cover: read 0x0002 and read 0x8000 -> rsp_err=1, rdata=0; write to 0x8000 -> no state change, rsp_err=1.
REQ-036 SHALL cover: assert rst while mtip[0]=1 and a read is in flight -> next cycle mtip=0, rsp_valid=0, mtime=0.
